// File: rtl/sram_ctrl.sv
// Request/response front-end for a bit-cell array: registered selects/strobes,
// 2-cycle read with held response, and a word-by-word hardware clear sequencer.
module sram_ctrl #(
   parameter int  ROWS       = 64,
   parameter int  COLS       = 64,
   parameter int  DATA_WIDTH = 8,
   localparam int WPR        = COLS / DATA_WIDTH,
   localparam int WORDS      = ROWS * WPR,
   localparam int ADDR_W     = $clog2(WORDS),
   localparam int COL_W      = $clog2(WPR),
   localparam int ROW_W      = $clog2(ROWS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   input  logic                  clear_start,
   output logic                  clear_busy,
   output logic [ROW_W-1:0]      arr_row_select,
   output logic [COL_W-1:0]      arr_col_select,
   output logic [DATA_WIDTH-1:0] arr_write_enable,
   output logic [DATA_WIDTH-1:0] arr_data_in,
   input  logic [DATA_WIDTH-1:0] arr_data_out
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_t;

   state_t                state_q, state_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [COL_W-1:0]      col_q, col_d;
   logic [DATA_WIDTH-1:0] we_q, we_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  is_wr_q, is_wr_d;
   logic [ADDR_W-1:0]     cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         row_q       <= '0;
         col_q       <= '0;
         we_q        <= '0;
         din_q       <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         is_wr_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         we_q        <= we_d;
         din_q       <= din_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         is_wr_q     <= is_wr_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      we_d        = we_q;
      din_d       = din_q;
      rdata_d     = rdata_q;
      rsp_valid_d = rsp_valid_q;
      is_wr_d     = is_wr_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            // clear_start wins; a coincident request simply stays pending
            if (clear_start) begin
               state_d        = CLEAR;
               cnt_d          = '0;
               {row_d, col_d} = '0;
               we_d           = '1;
               din_d          = '0;
            end else if (req_valid) begin
               state_d        = ACCESS;
               {row_d, col_d} = req_addr;
               is_wr_d        = req_write;
               we_d           = req_write ? req_wmask : '0;
               din_d          = req_write ? req_wdata : '0;
            end
         end
         ACCESS: begin
            we_d  = '0;
            din_d = '0;
            if (is_wr_q) begin
               state_d = IDLE;
            end else begin
               rdata_d     = arr_data_out;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         CLEAR: begin
            if (cnt_q == ADDR_W'(WORDS - 1)) begin
               we_d    = '0;
               state_d = IDLE;
            end else begin
               cnt_d          = cnt_q + 1'b1;
               {row_d, col_d} = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready        = (state_q == IDLE) && !clear_start && !rst;
   assign rsp_valid        = rsp_valid_q;
   assign rsp_rdata        = rdata_q;
   assign clear_busy       = (state_q == CLEAR);
   assign arr_row_select   = row_q;
   assign arr_col_select   = col_q;
   assign arr_write_enable = we_q;
   assign arr_data_in      = din_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed plus randomized bench for sram_ctrl with a behavioural array and
// a word-level reference memory.
module tb_sram_ctrl;

   logic       clk, rst;
   logic       req_valid, req_ready, req_write;
   logic [8:0] req_addr;
   logic [7:0] req_wdata, req_wmask;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_rdata;
   logic       clear_start, clear_busy;
   logic [5:0] arr_row_select;
   logic [2:0] arr_col_select;
   logic [7:0] arr_write_enable, arr_data_in, arr_data_out;

   int checks = 0;
   int errors = 0;

   sram_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .req_wmask        (req_wmask),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_rdata        (rsp_rdata),
      .clear_start      (clear_start),
      .clear_busy       (clear_busy),
      .arr_row_select   (arr_row_select),
      .arr_col_select   (arr_col_select),
      .arr_write_enable (arr_write_enable),
      .arr_data_in      (arr_data_in),
      .arr_data_out     (arr_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit-cell array: combinational read, per-bit write on the rising edge.
   logic [7:0] mem [0:511];
   logic       preload;
   logic [7:0] ref_mem [0:511];
   wire  [8:0] arr_idx = {arr_row_select, arr_col_select};
   assign arr_data_out = mem[arr_idx];

   function automatic logic [7:0] init_val(int i);
      return 8'((i * 37 + 11) ^ (i >> 2));
   endfunction

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
      end else if (|arr_write_enable) begin
         mem[arr_idx] <= (mem[arr_idx] & ~arr_write_enable) | (arr_data_in & arr_write_enable);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int w = 0;
      while (!req_ready && w < 1000) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic write_op(input logic [8:0] a, input logic [7:0] d, input logic [7:0] m);
      wait_ready();
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("wr_strobe", {7'd0, arr_row_select, arr_col_select, arr_write_enable, arr_data_in},
          {7'd0, a, m, d});
      @(negedge clk);
      chk("wr_done", {23'd0, arr_write_enable, req_ready, rsp_valid}, {23'd0, 8'h00, 1'b1, 1'b0});
      ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
   endtask

   task automatic read_op(input logic [8:0] a, input int hold, input logic [7:0] exp);
      wait_ready();
      req_valid = 1'b1; req_write = 1'b0; req_addr = a;
      req_wdata = 8'($urandom); req_wmask = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rd_access", {14'd0, arr_row_select, arr_col_select, arr_write_enable, rsp_valid},
          {14'd0, a, 8'h00, 1'b0});
      @(negedge clk);
      chk("rd_rsp", {23'd0, rsp_valid, rsp_rdata}, {23'd0, 1'b1, exp});
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("rd_hold", {22'd0, rsp_valid, rsp_rdata, req_ready}, {22'd0, 1'b1, exp, 1'b0});
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("rd_release", {30'd0, rsp_valid, req_ready}, {30'd0, 1'b0, 1'b1});
      rsp_ready = 1'b0;
   endtask

   // abort_at < 0 runs a full clear; coll issues a read of word 200 together with clear_start.
   task automatic clear_op(input int abort_at, input bit coll);
      int  n = 0;
      bit  aborted = 1'b0;
      wait_ready();
      clear_start = 1'b1;
      if (coll) begin
         req_valid = 1'b1; req_write = 1'b0; req_addr = 9'd200;
      end
      #1;
      chk("clr_prio_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      clear_start = 1'b0;
      while (clear_busy && n < 600 && !aborted) begin
         chk("clr_seq", {6'd0, req_ready, arr_row_select, arr_col_select, arr_write_enable, arr_data_in},
             {6'd0, 1'b0, 9'(n), 8'hff, 8'h00});
         if (n == abort_at) begin
            rst = 1'b1;
            #1;
            chk("abort_outs", {5'd0, clear_busy, req_ready, rsp_valid, arr_row_select, arr_col_select,
                               arr_write_enable, arr_data_in}, 32'd0);
            aborted = 1'b1;
         end else begin
            n++;
            @(negedge clk);
         end
      end
      if (aborted) begin
         for (int i = 0; i < abort_at; i++) ref_mem[i] = 8'h00;
         @(negedge clk);
         chk("abort_rst_ready", {31'd0, req_ready}, 32'd0);
         rst = 1'b0;
         @(negedge clk);
         chk("abort_release", {30'd0, req_ready, clear_busy}, {30'd0, 1'b1, 1'b0});
      end else begin
         chk("clr_len", 32'(n), 32'd512);
         chk("clr_end", {23'd0, clear_busy, arr_write_enable}, 32'd0);
         for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
         if (coll) begin
            chk("coll_ready", {31'd0, req_ready}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            chk("coll_access", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
            chk("coll_rsp", {23'd0, rsp_valid, rsp_rdata}, {23'd0, 1'b1, ref_mem[200]});
            rsp_ready = 1'b1;
            @(negedge clk);
            chk("coll_release", {31'd0, rsp_valid}, 32'd0);
            rsp_ready = 1'b0;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; preload = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
      rsp_ready = 1'b0; clear_start = 1'b0;
      for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
      repeat (2) @(negedge clk);
      preload = 1'b0;
      chk("rst_outs", {3'd0, req_ready, rsp_valid, rsp_rdata, clear_busy, arr_row_select,
                       arr_col_select, arr_write_enable}, 32'd0);
      chk("rst_din", {24'd0, arr_data_in}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_release_ready", {30'd0, req_ready, clear_busy}, {30'd0, 1'b1, 1'b0});

      // 0x1A5 splits into row 52, column 5
      write_op(9'h1A5, 8'h3C, 8'hFF);
      chk("split_row_col", {23'd0, req_addr}, {23'd0, 6'd52, 3'd5});
      read_op(9'h1A5, 0, 8'h3C);

      write_op(9'd7, 8'hFF, 8'hFF);
      write_op(9'd7, 8'h00, 8'h0F);
      read_op(9'd7, 0, 8'hF0);
      write_op(9'd7, 8'h00, 8'h00);
      read_op(9'd7, 0, 8'hF0);

      read_op(9'h1A5, 5, 8'h3C);

      write_op(9'd0, 8'hAA, 8'hFF);
      write_op(9'd255, 8'h55, 8'hFF);
      write_op(9'd511, 8'hC3, 8'hFF);
      clear_op(-1, 1'b0);
      read_op(9'd0, 0, 8'h00);
      read_op(9'd255, 1, 8'h00);
      read_op(9'd511, 0, 8'h00);

      write_op(9'd200, 8'h5A, 8'hFF);
      write_op(9'd50, 8'h77, 8'hFF);
      write_op(9'd100, 8'h99, 8'hFF);
      clear_op(100, 1'b0);
      read_op(9'd50, 0, 8'h00);
      read_op(9'd99, 0, 8'h00);
      read_op(9'd100, 0, 8'h99);
      read_op(9'd200, 0, 8'h5A);

      clear_op(-1, 1'b1);

      for (int k = 0; k < 150; k++) begin
         logic [8:0] a;
         a = ($urandom % 2 == 0) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
         if ($urandom % 2 == 0)
            write_op(a, 8'($urandom), 8'($urandom));
         else
            read_op(a, int'($urandom_range(0, 3)), ref_mem[a]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Request/response front-end that drives the bit-cell array's row/column/write-enable/data interface and captures its combinational read port.
- Converts flat word addresses and byte-lane masks into array select and enable strobes, and registers read data toward the consumer.
- Provides a hardware clear sequencer that zeroes every word after power-up or on demand.
- Sits between the system-side client and the array instance, one controller per array.

Parameters:
- ROWS, 64, number of array rows.
- COLS, 64, number of array columns (bits per row).
- DATA_WIDTH, 8, word width in bits. COLS/DATA_WIDTH must be a power of two and at least 2.
- Derived: WORDS = ROWS*COLS/DATA_WIDTH (default 512), ADDR_W = $clog2(WORDS), COL_W = $clog2(COLS/DATA_WIDTH), ROW_W = $clog2(ROWS).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  DATA_WIDTH  per-bit write enable.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  DATA_WIDTH  read data.
- clear_start  in  1  start a full-array clear.
- clear_busy  out  1  clear in progress.
- arr_row_select  out  ROW_W  to array row_select.
- arr_col_select  out  COL_W  to array col_select.
- arr_write_enable  out  DATA_WIDTH  to array write_enable.
- arr_data_in  out  DATA_WIDTH  to array data_in.
- arr_data_out  in  DATA_WIDTH  from array data_out (combinational in the selects).

Behaviour:
- Reset (async, rst high): state IDLE. All array outputs are 0, rsp_valid is 0, rsp_rdata is 0, clear_busy is 0, clear counter is 0. req_ready is forced to 0 while rst is high.
- Address split: arr_row_select = addr[ADDR_W-1:COL_W], arr_col_select = addr[COL_W-1:0]. All arr_* outputs are registered.
- States: IDLE, ACCESS, RESP, CLEAR.
- req_ready = (state == IDLE) && !clear_start && !rst.
- Accept condition: req_valid && req_ready.
- IDLE → ACCESS on accept at edge T:
  - Latch the selects.
  - Write: arr_write_enable = req_wmask and arr_data_in = req_wdata for exactly one cycle (T+1).
  - Read: arr_write_enable = 0.
- ACCESS → (edge T+2):
  - arr_write_enable returns to 0.
  - Write: go to IDLE. No response is generated.
  - Read: rsp_rdata ← arr_data_out, rsp_valid ← 1, go to RESP.
- Read latency: rsp_valid rises 2 cycles after accept.
- Write occupancy: 2 cycles, so the earliest next accept is at T+2. A read issued at that point returns the newly written data.
- Zero-mask write: same timing, no cell changes.
- RESP: rsp_valid and rsp_rdata are held stable until rsp_valid && rsp_ready. At that edge rsp_valid ← 0 and state ← IDLE. No new request is accepted in the same cycle as the response handshake.
- IDLE → CLEAR when clear_start is high at an edge in IDLE. clear_start has priority over req_valid in the same cycle; the request stays pending.
  - Entry: cnt = 0, select = address 0, arr_write_enable = all ones, arr_data_in = 0.
- CLEAR, each edge:
  - If cnt == WORDS-1: arr_write_enable ← 0, state ← IDLE.
  - Otherwise: cnt++ and selects ← cnt+1.
- clear_busy = (state == CLEAR), high for exactly WORDS cycles.
- clear_start is ignored outside IDLE, and ignored while clear_busy is high (no restart).
- Reset mid-operation: everything aborts immediately and arr_write_enable drops asynchronously. The array keeps whatever was written so far (partial clear, or possibly no write). Any pending response is lost.
- The address space is exactly WORDS words, so every ADDR_W value maps to a real word. No wrap or out-of-range case exists.

Test Plan:
- Reset: assert rst mid-cycle → all outputs 0 immediately and req_ready 0. Release → req_ready 1 on the next cycle, state IDLE.
- Write addr 0x1A5, data 0x3C, mask 0xFF, then read 0x1A5:
  - Write cycle: arr_row_select 52, arr_col_select 5, arr_write_enable 0xFF for exactly 1 cycle.
  - Read: rsp_valid 2 cycles after accept, rsp_rdata 0x3C.
- Masked write: pre-write 0xFF to addr 7, then write 0x00 with mask 0x0F → readback 0xF0. Follow with a mask-0x00 write of 0x00 → readback still 0xF0.
- Response backpressure: read with rsp_ready held low 5 cycles → rsp_valid and rsp_rdata stable, req_ready 0 throughout. Raising rsp_ready → rsp_valid drops next edge, req_ready returns 1.
- Clear: fill several words with nonzero data, pulse clear_start → clear_busy high exactly 512 cycles, addresses sequential 0..511 with we 0xFF and data 0. Afterwards reads of addresses 0, 255 and 511 return 0x00.
- Collision and abort:
  - clear_start together with req_valid → clear wins, the request is accepted only after clear_busy falls.
  - rst at clear cycle 100 → words 0..99 zero, word 200 keeps its old value, clear_busy 0 immediately.
